// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the BRAM stream reader.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = 2;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready word stream produced by the BRAM stream reader.
interface bram_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_last;
  logic                  i_ready;

  modport master (output o_valid, output o_data, output o_last, input i_ready);
  modport slave  (input o_valid, input o_data, input o_last, output i_ready);
endinterface

// File: rtl/bram_reader_fifo2.sv
// Two-entry shift FIFO; entry 0 is always the head, push and pop may coincide.
module bram_reader_fifo2
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 65
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_data,
  input  logic                  i_pop,
  output logic [FIFO_CNT_W-1:0] o_count,
  output logic [WIDTH-1:0]      o_head
);

  logic [WIDTH-1:0]      ent0_q, ent0_d;
  logic [WIDTH-1:0]      ent1_q, ent1_d;
  logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pop_ok, push_ok;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    cnt_d   = cnt_q;
    pop_ok  = i_pop && (cnt_q != FIFO_CNT_W'(0));
    push_ok = i_push && ((cnt_q != FIFO_CNT_W'(FIFO_DEPTH)) || pop_ok);
    case ({push_ok, pop_ok})
      2'b10: begin
        if (cnt_q == FIFO_CNT_W'(0)) ent0_d = i_push_data;
        else                         ent1_d = i_push_data;
        cnt_d = cnt_q + FIFO_CNT_W'(1);
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - FIFO_CNT_W'(1);
      end
      2'b11: begin
        // Occupancy unchanged: new word lands behind whatever remains.
        if (cnt_q == FIFO_CNT_W'(1)) begin
          ent0_d = i_push_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = i_push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_count = cnt_q;
  assign o_head  = ent0_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a run of consecutive BRAM words and streams them out with backpressure.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH:0]   i_word_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_write,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  bram_stream_reader_if.master  strm
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned ENT_W = DATA_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  busy_q, done_q;

  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [ENT_W-1:0]      fifo_head;
  logic                  pop, issue;
  logic [2:0]            occupancy;

  assign pop       = strm.o_valid & strm.i_ready;
  // Words that will be held after this edge if nothing new is issued.
  assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    issue           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_word_count != CNT_W'(0)) begin
            addr_d   = i_start_addr;
            remain_d = i_word_count;
            state_d  = ST_READ;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_READ: begin
        if (occupancy < 3'd2) begin
          issue    = 1'b1;
          addr_d   = addr_q + ADDR_WIDTH'(1);
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as the final word transfers so done lands in the following cycle.
        if (!inflight_q && ((fifo_count == FIFO_CNT_W'(0)) ||
                            ((fifo_count == FIFO_CNT_W'(1)) && pop)))
          state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    inflight_d      = issue;
    inflight_last_d = issue && (remain_q == CNT_W'(1));
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= (state_d != ST_IDLE);
      done_q          <= (state_d == ST_DONE);
    end
  end

  bram_reader_fifo2 #(.WIDTH(ENT_W)) u_fifo (
    .i_clk       (i_clk),
    .i_areset_n  (i_areset_n),
    .i_push      (inflight_q),
    .i_push_data ({inflight_last_q, i_ram_data}),
    .i_pop       (pop),
    .o_count     (fifo_count),
    .o_head      (fifo_head)
  );

  assign strm.o_valid = (fifo_count != FIFO_CNT_W'(0));
  assign strm.o_data  = fifo_head[DATA_WIDTH-1:0];
  assign strm.o_last  = strm.o_valid & fifo_head[DATA_WIDTH];

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_ram_addr  = addr_q;
  assign o_ram_write = 1'b0;
  assign o_ram_data  = '0;

endmodule
